instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch_next_pc_calc.sv | 24 ++
 rtl/instr_fetch.sv | 72 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-state type, word width and MIPS opcode/funct encodings
package mips_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} fetch_state_t;
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and decode-side bundle of the fetch unit
// master (fetch unit): drives imem_req/imem_addr, instr/instr_valid/pc_plus4, fetch_err
// slave (memory + decode/control): drives imem_ack/imem_rdata, decode_ready,
//   Jump/JumpReg/Branch/br_taken and rs_data
interface instr_fetch_if;
  import mips_pkg::*;
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic [WORD_W-1:0] pc_plus4;
  logic              decode_ready;
  logic              Jump;
  logic              JumpReg;
  logic              Branch;
  logic              br_taken;
  logic [WORD_W-1:0] rs_data;
  logic              fetch_err;
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_plus4, fetch_err,
    input  imem_ack, imem_rdata, decode_ready, Jump, JumpReg, Branch, br_taken, rs_data
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_plus4, fetch_err,
    output imem_ack, imem_rdata, decode_ready, Jump, JumpReg, Branch, br_taken, rs_data
  );
endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// next_pc_calc: combinational next-PC select for jr / j / taken branch / sequential
// pcPlus4, instrIdx (instr[25:0]), rsData, jumpReg, jump, branch, brTaken -> nextPc
// All sums wrap modulo 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pcPlus4,
  input  logic [25:0]       instrIdx,
  input  logic [WORD_W-1:0] rsData,
  input  logic              jumpReg,
  input  logic              jump,
  input  logic              branch,
  input  logic              brTaken,
  output logic [WORD_W-1:0] nextPc
);
  logic [WORD_W-1:0] jumpTarget, branchTarget;
  always_comb begin
    jumpTarget   = {pcPlus4[31:28], instrIdx, 2'b00};
    branchTarget = pcPlus4 + {{14{instrIdx[15]}}, instrIdx[15:0], 2'b00};
    nextPc = jumpReg ? rsData :
             jump ? jumpTarget :
             (branch && brTaken) ? branchTarget : pcPlus4;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding MIPS instruction fetch FSM (IDLE/REQ/HOLD/ERR)
// clk, reset (sync, active-high); bus: instr_fetch_if.master
// RESET_PC: word-aligned PC loaded on reset
// FETCH_ALIGN_CHECK_EN: when defined, a misaligned next-PC traps into ERR (sticky
//   fetch_err until reset); when undefined the low two target bits are cleared.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.master bus
);
  fetch_state_t state, nextState;
  logic [WORD_W-1:0] pc, instrReg, pcPlus4Reg, nextPc, targetPc;
  logic accept, misaligned;
  next_pc_calc uNextPc (
    .pcPlus4 (pcPlus4Reg),
    .instrIdx(instrReg[25:0]),
    .rsData  (bus.rs_data),
    .jumpReg (bus.JumpReg),
    .jump    (bus.Jump),
    .branch  (bus.Branch),
    .brTaken (bus.br_taken),
    .nextPc  (nextPc)
  );
  assign accept = (state == HOLD) && bus.decode_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |nextPc[1:0];
  assign targetPc   = nextPc;
`else
  assign misaligned = 1'b0;
  assign targetPc   = {nextPc[WORD_W-1:2], 2'b00};
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end
  always_comb begin
    nextState = state == IDLE ? REQ :
                state == REQ  ? (bus.imem_ack ? HOLD : REQ) :
                state == HOLD ? (!accept ? HOLD : misaligned ? ERR : REQ) :
                state;
  end
  // Datapath registers; ack is only meaningful while a read is outstanding (REQ).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      instrReg   <= '0;
      pcPlus4Reg <= '0;
    end else begin
      if (state == REQ && bus.imem_ack) begin
        instrReg   <= bus.imem_rdata;
        pcPlus4Reg <= pc + 32'd4;
      end
      if (accept && !misaligned) pc <= targetPc;
    end
  end
  always_comb begin
    bus.imem_req    = state == REQ;
    bus.imem_addr   = state == REQ ? pc : '0;
    bus.instr_valid = state == HOLD;
    bus.instr       = instrReg;
    bus.pc_plus4    = pcPlus4Reg;
`ifdef FETCH_ALIGN_CHECK_EN
    bus.fetch_err   = state == ERR;
`else
    bus.fetch_err   = 1'b0;
`endif
  end
endmodule
